// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-through cache controller, 16 lines x 1 word
module cache_controller #(
    parameter int MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [7:0]  cpu_adr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        busy,
    output logic [7:0]  mem_adr,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_read_data,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, RESP} state_t;

    localparam logic [3:0] LAST_WAIT = 4'(MEM_WAIT - 1);

    state_t      state;
    logic [15:0] line_data [16];
    logic [3:0]  line_tag  [16];
    logic [15:0] valid;

    logic [7:0]  req_adr;
    logic        req_we;
    logic [15:0] req_wdata;
    logic [3:0]  wait_cnt;

    logic [3:0]  cpu_idx;
    logic [3:0]  cpu_tag;
    logic [3:0]  req_idx;
    logic        cpu_hit;
    logic        req_hit;
    logic        fill_done;
    logic        write_update;

    assign cpu_idx      = cpu_adr[3:0];
    assign cpu_tag      = cpu_adr[7:4];
    assign req_idx      = req_adr[3:0];
    assign cpu_hit      = valid[cpu_idx] && (line_tag[cpu_idx] == cpu_tag);
    assign req_hit      = valid[req_idx] && (line_tag[req_idx] == req_adr[7:4]);
    assign fill_done    = (state == FILL) && (wait_cnt == LAST_WAIT);
    // A write that misses leaves the line alone (no-write-allocate).
    assign write_update = (state == WRITE) && req_hit;

    // Line data and tag storage; unreset because valid gates visibility.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            line_data[req_idx] <= mem_read_data;
            line_tag[req_idx]  <= req_adr[7:4];
        end else if (write_update) begin
            line_data[req_idx] <= req_wdata;
        end
    end

    // Control FSM with registered outputs, statistics and valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            valid          <= '0;
            cpu_ready      <= 1'b0;
            busy           <= 1'b0;
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_adr        <= '0;
            mem_write_data <= '0;
            cpu_rdata      <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            req_adr        <= '0;
            req_we         <= 1'b0;
            req_wdata      <= '0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ready <= 1'b0;
                    // The CPU still holds cpu_req during the ready pulse, so ignore it then.
                    if (cpu_req && !cpu_ready) begin
                        req_adr   <= cpu_adr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                        busy      <= 1'b1;
                        if (cpu_we) begin
                            mem_adr        <= cpu_adr;
                            mem_write_data <= cpu_wdata;
                            mem_write_en   <= 1'b1;
                            state          <= WRITE;
                        end else if (cpu_hit) begin
                            cpu_rdata <= line_data[cpu_idx];
                            hit_count <= hit_count + 16'd1;
                            state     <= RESP;
                        end else begin
                            mem_adr     <= cpu_adr;
                            mem_read_en <= 1'b1;
                            wait_cnt    <= '0;
                            miss_count  <= miss_count + 16'd1;
                            state       <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (wait_cnt == LAST_WAIT) begin
                        cpu_rdata      <= mem_read_data;
                        valid[req_idx] <= 1'b1;
                        mem_read_en    <= 1'b0;
                        state          <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                WRITE: begin
                    mem_write_en <= 1'b0;
                    state        <= RESP;
                end
                RESP: begin
                    cpu_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cache_controller.md
CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 2, number of cycles mem_read_en is held per line fill (legal range 1..15).
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cpu_req  input  1  CPU access request, held stable by CPU until cpu_ready.
REQ-005 SHALL have port cpu_we  input  1  1 = write, 0 = read; valid with cpu_req.
REQ-006 SHALL have port cpu_adr  input  8  word address; tag = [7:4], index = [3:0].
REQ-007 SHALL have port cpu_wdata  input  16  write data.
REQ-008 SHALL have port cpu_rdata  output  16  read data, valid while cpu_ready = 1.
REQ-009 SHALL have port cpu_ready  output  1  one-cycle completion pulse.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port mem_adr  output  8  word memory address.
REQ-012 SHALL have port mem_read_en  output  1  memory read enable; memory returns data combinationally.
REQ-013 SHALL have port mem_write_en  output  1  memory write enable; memory writes on the rising edge.
REQ-014 SHALL have port mem_write_data  output  16  memory write data.
REQ-015 SHALL have port mem_read_data  input  16  memory read data.
REQ-016 SHALL have port hit_count, miss_count  output  16 each  read hit / read miss statistics.

Function
REQ-017 SHALL implement a direct-mapped cache of 16 lines x 1 word, each line with a valid bit and a 4-bit tag; write-through, no-write-allocate.
REQ-018 SHALL register all outputs; no output is combinational from inputs.
REQ-019 SHALL use states IDLE, FILL, WRITE, RESP.
REQ-020 IDLE: cpu_req sampled only here; on cpu_req, latch cpu_adr, cpu_we and cpu_wdata.
REQ-021 IDLE, read hit (valid[idx] and tag match): load cpu_rdata from line, go to RESP, increment hit_count.
REQ-022 IDLE, read miss: drive mem_adr = cpu_adr, mem_read_en = 1, clear wait counter, go to FILL, increment miss_count.
REQ-023 FILL: keep mem_read_en = 1 for exactly MEM_WAIT cycles; on the last cycle capture mem_read_data into line data, cpu_rdata and tag, set valid, drop mem_read_en and go to RESP.
REQ-024 IDLE, write: drive mem_adr, mem_write_data = cpu_wdata, mem_write_en = 1, go to WRITE.
REQ-025 WRITE: lasts exactly one cycle; mem_write_en deasserts on exit; on a hit, line data updates to cpu_wdata; on a miss, cache state is unchanged; go to RESP.
REQ-026 RESP: cpu_ready = 1 for exactly one cycle, then IDLE; a new request is accepted no earlier than the cycle after the pulse.
REQ-027 Read latency, req to cpu_ready: hit = 2 cycles; miss = MEM_WAIT + 2 cycles; write = 3 cycles.
REQ-028 mem_read_en and mem_write_en SHALL never be high in the same cycle.
REQ-029 Write to an index holding a different tag SHALL not disturb that line.
REQ-030 hit_count and miss_count SHALL wrap from 16'hFFFF to 0; writes SHALL not change either counter.
REQ-031 Read after write to the same address SHALL return the written data (hit if line valid, else refill from memory).
REQ-032 cpu_req low in IDLE: all memory enables low, no state change.

Reset
REQ-033 While rst = 1: state = IDLE, all valid bits = 0, cpu_ready = 0, busy = 0, mem_read_en = 0, mem_write_en = 0, mem_adr = 0, mem_write_data = 0, cpu_rdata = 0, hit_count = 0, miss_count = 0.
REQ-034 rst mid-FILL or mid-WRITE SHALL abort immediately: enables drop asynchronously, no line is validated, no cpu_ready is issued.
REQ-035 Line data and tag storage need not be reset; valid = 0 makes them unobservable.

Verification
REQ-036 Cold read: read adr 8'h35, memory holds 16'hBEEF, MEM_WAIT = 2 -> mem_read_en high 2 cycles, cpu_ready at cycle 4 with cpu_rdata = 16'hBEEF, miss_count = 1.
REQ-037 Repeat the read of 8'h35 -> cpu_ready at cycle 2, no mem_read_en, cpu_rdata = 16'hBEEF, hit_count = 1.
REQ-038 Write 16'h1234 to 8'h35, then read 8'h35 -> one-cycle mem_write_en with mem_adr = 8'h35; read hits and returns 16'h1234.
REQ-039 Conflict: read 8'h35, then read 8'h45 (memory holds 16'h0A0A), then read 8'h35 -> three misses; the second returns 16'h0A0A.
REQ-040 Assert rst in the second FILL cycle -> all outputs 0 asynchronously, no cpu_ready; a following read of the same address misses.
REQ-041 Write to 8'h77 on a cold cache, then read 8'h77 -> write leaves valid[7] = 0; read misses and returns the memory value just written.
